// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: assembles W MSB-first bits into a registered word plus parity.
// Latency: P/PAR/V update on the same edge that samples the W-th enabled bit.
// Backpressure: none; EN gates sampling, FL drops a partial word, V is a single-cycle strobe.
module sipo_deser #(
    parameter int W = 8
) (
    input  logic                 C,
    input  logic                 nR,
    input  logic                 D,
    input  logic                 EN,
    input  logic                 FL,
    output logic [W-1:0]         P,
    output logic                 V,
    output logic [$clog2(W)-1:0] CNT,
    output logic                 PAR
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    logic [W-1:0]  sr_q,  sr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  p_q,   p_d;
    logic          par_q, par_d;
    logic          v_q,   v_d;

    always_comb begin
        sr_d  = sr_q;
        cnt_d = cnt_q;
        p_d   = p_q;
        par_d = par_q;
        v_d   = 1'b0;
        // Flush outranks enable so a bit presented alongside FL is dropped.
        if (FL) begin
            sr_d  = '0;
            cnt_d = '0;
        end else if (EN) begin
            sr_d = {sr_q[W-2:0], D};
            if (cnt_q == LAST_BIT) begin
                p_d   = sr_d;
                par_d = ^sr_d;
                v_d   = 1'b1;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge C) begin
        if (!nR) begin
            sr_q  <= '0;
            cnt_q <= '0;
            p_q   <= '0;
            par_q <= 1'b0;
            v_q   <= 1'b0;
        end else begin
            sr_q  <= sr_d;
            cnt_q <= cnt_d;
            p_q   <= p_d;
            par_q <= par_d;
            v_q   <= v_d;
        end
    end

    assign P   = p_q;
    assign V   = v_q;
    assign CNT = cnt_q;
    assign PAR = par_q;

endmodule

// File: tb/tb_sipo_deser.sv
// Bench for sipo_deser: directed scenarios then random traffic, each edge checked against a bit-queue model.
module tb_sipo_deser;

    localparam int W = 8;

    logic                 C;
    logic                 nR;
    logic                 D;
    logic                 EN;
    logic                 FL;
    logic [W-1:0]         P;
    logic                 V;
    logic [$clog2(W)-1:0] CNT;
    logic                 PAR;

    int errors = 0;
    int checks = 0;

    // Model: the bits of the word in progress, oldest first, plus the last published word.
    int           m_bits[$];
    logic [W-1:0] m_p   = '0;
    logic         m_par = 1'b0;
    logic         m_v   = 1'b0;

    sipo_deser #(.W(W)) dut (
        .C   (C),
        .nR  (nR),
        .D   (D),
        .EN  (EN),
        .FL  (FL),
        .P   (P),
        .V   (V),
        .CNT (CNT),
        .PAR (PAR)
    );

    initial C = 1'b0;
    always #5 C = ~C;

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "simulation did not finish");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge(input logic en, input logic d, input logic fl, input logic nr);
        int w;
        m_v = 1'b0;
        if (!nr) begin
            m_bits.delete();
            m_p   = '0;
            m_par = 1'b0;
        end else if (fl) begin
            m_bits.delete();
        end else if (en) begin
            m_bits.push_back(int'(d));
            if (m_bits.size() == W) begin
                w = 0;
                foreach (m_bits[i]) w = w * 2 + m_bits[i];
                m_p   = w[W-1:0];
                m_par = ($countones(w) % 2) == 1;
                m_v   = 1'b1;
                m_bits.delete();
            end
        end
    endtask

    task automatic step(input logic en, input logic d, input logic fl, input logic nr);
        EN = en; D = d; FL = fl; nR = nr;
        @(posedge C);
        #1;
        model_edge(en, d, fl, nr);
        chk("P",   32'(P),   32'(m_p));
        chk("V",   32'(V),   32'(m_v));
        chk("CNT", 32'(CNT), 32'(m_bits.size()));
        chk("PAR", 32'(PAR), 32'(m_par));
    endtask

    task automatic send_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) step(1'b1, w[i], 1'b0, 1'b1);
    endtask

    initial begin
        EN = 1'b0; D = 1'b0; FL = 1'b0; nR = 1'b0;
        #1;

        // Reset held for two edges with EN=1, D=1.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("reset_P", 32'(P), 32'h0);
        chk("reset_CNT", 32'(CNT), 32'h0);

        // Basic word 0xB2.
        send_word(8'hB2);
        chk("basic_P", 32'(P), 32'hB2);
        chk("basic_V", 32'(V), 32'h1);
        chk("basic_PAR", 32'(PAR), 32'h0);
        step(1'b0, 1'bx, 1'b0, 1'b1);
        chk("basic_V_drop", 32'(V), 32'h0);

        // Same bits with two idle cycles after bits 3 and 6; D is X while idle.
        begin
            logic [W-1:0] w;
            w = 8'hB2;
            for (int i = W - 1; i >= 0; i--) begin
                step(1'b1, w[i], 1'b0, 1'b1);
                if (i == 5 || i == 2) begin
                    step(1'b0, 1'bx, 1'b0, 1'b1);
                    step(1'b0, 1'bx, 1'b0, 1'b1);
                    chk("gap_CNT", 32'(CNT), (i == 5) ? 32'd3 : 32'd6);
                    chk("gap_V", 32'(V), 32'h0);
                end
            end
            chk("gap_P", 32'(P), 32'hB2);
            chk("gap_V_final", 32'(V), 32'h1);
        end

        // Three ones, flush with EN=1, then 0xC1.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        chk("flush_CNT", 32'(CNT), 32'h0);
        send_word(8'hC1);
        chk("flush_P", 32'(P), 32'hC1);
        chk("flush_PAR", 32'(PAR), 32'h1);

        // Back-to-back 0xA5 then 0x3C with no idle cycle.
        send_word(8'hA5);
        chk("b2b_P1", 32'(P), 32'hA5);
        for (int i = W - 1; i >= 1; i--) begin
            logic [W-1:0] w;
            w = 8'h3C;
            step(1'b1, w[i], 1'b0, 1'b1);
            chk("b2b_hold", 32'(P), 32'hA5);
        end
        step(1'b1, 1'b0, 1'b0, 1'b1);
        chk("b2b_P2", 32'(P), 32'h3C);
        chk("b2b_V2", 32'(V), 32'h1);

        // Five bits, reset mid-word, then 0x5A.
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        chk("mrst_CNT", 32'(CNT), 32'h0);
        chk("mrst_P", 32'(P), 32'h0);
        send_word(8'h5A);
        chk("mrst_P2", 32'(P), 32'h5A);
        chk("mrst_PAR", 32'(PAR), 32'h0);

        // Random traffic: mostly enabled, occasional flush and reset.
        for (int n = 0; n < 600; n++) begin
            logic en, d, fl, nr;
            en = ($urandom_range(0, 3) != 0);
            d  = en ? 1'($urandom_range(0, 1)) : 1'bx;
            fl = ($urandom_range(0, 29) == 0);
            nr = ($urandom_range(0, 79) != 0);
            step(en, d, fl, nr);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
